// File: rtl/riscv_m_pkg.sv
// Shared RV32M definitions: funct3 codes, FSM state encoding and operand sign conditioning.
package riscv_m_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Returns {negative, magnitude}; the magnitude of the most negative value still fits in XLEN bits.
    function automatic logic [XLEN:0] abs_sign(input logic [XLEN-1:0] v, input logic is_signed);
        logic neg;
        neg = is_signed & v[XLEN-1];
        return {neg, (neg ? -v : v)};
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 34-cycle start-to-done, one op in flight, start ignored while busy.
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip the iteration (done 2 cycles after accept).
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic            wb_en,
    output logic [4:0]      rd_out,
    output logic [XLEN-1:0] result
);
    import riscv_m_pkg::*;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        f3_q;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   mcand_q;
    logic [XLEN-1:0]   a_raw_q;
    logic [2*XLEN-1:0] acc_q;
    logic              sign_a_q, sign_b_q, div_zero_q, div_ovf_q;

    logic            accept, take_early;
    logic            a_signed, b_signed, in_zero, in_ovf;
    logic [XLEN:0]   a_cond, b_cond;

    assign ready  = (state_q == S_IDLE) || (state_q == S_DONE);
    assign busy   = (state_q == S_CALC) || (state_q == S_FIX);
    assign done   = (state_q == S_DONE);
    assign wb_en  = done;
    assign accept = ready & start & ~kill;

    assign a_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                      (funct3 == F3_DIV)  || (funct3 == F3_REM);
    assign b_signed = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
    assign a_cond   = abs_sign(op_a, a_signed);
    assign b_cond   = abs_sign(op_b, b_signed);
    assign in_zero  = funct3[2] && (op_b == '0);
    assign in_ovf   = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                      (op_a == MIN_NEG) && (op_b == '1);

`ifdef MULDIV_EARLY_OUT_EN
    assign take_early = in_zero | in_ovf;
`else
    assign take_early = 1'b0;
`endif

    // acc holds {hi, lo}: product accumulator / multiplier for MUL*, remainder / quotient for DIV*.
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_sh;
    logic [XLEN-1:0]   rem_diff;
    logic [2*XLEN-1:0] acc_step;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        rem_sh   = acc_q[2*XLEN-1:XLEN-1];
        rem_diff = rem_sh[XLEN-1:0] - mcand_q;
        acc_step = {mul_sum, acc_q[XLEN-1:1]};
        if (f3_q[2]) begin
            if (rem_sh >= {1'b0, mcand_q})
                acc_step = {rem_diff, acc_q[XLEN-2:0], 1'b1};
            else
                acc_step = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end
    end

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, fix_val;

    always_comb begin
        prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
        quot_fix = (sign_a_q ^ sign_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = sign_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        fix_val  = '0;
        case (f3_q)
            F3_MUL:                       fix_val = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_val = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              fix_val = div_zero_q ? '1 : (div_ovf_q ? MIN_NEG : quot_fix);
            F3_REM, F3_REMU:              fix_val = div_zero_q ? a_raw_q : (div_ovf_q ? '0 : rem_fix);
            default:                      fix_val = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: state_d = start ? (take_early ? S_FIX : S_CALC) : S_IDLE;
            S_CALC:         if (cnt_q == '1) state_d = S_FIX;
            S_FIX:          state_d = S_DONE;
            default:        state_d = S_IDLE;
        endcase
        if (kill)
            state_d = S_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            f3_q       <= '0;
            rd_q       <= '0;
            mcand_q    <= '0;
            a_raw_q    <= '0;
            acc_q      <= '0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            div_zero_q <= 1'b0;
            div_ovf_q  <= 1'b0;
            rd_out     <= '0;
            result     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q      <= '0;
                f3_q       <= funct3;
                rd_q       <= rd_in;
                a_raw_q    <= op_a;
                mcand_q    <= b_cond[XLEN-1:0];
                acc_q      <= {{XLEN{1'b0}}, a_cond[XLEN-1:0]};
                sign_a_q   <= a_cond[XLEN];
                sign_b_q   <= b_cond[XLEN];
                div_zero_q <= in_zero;
                div_ovf_q  <= in_ovf;
            end else if (state_q == S_CALC) begin
                cnt_q <= cnt_q + CNT_W'(1);
                acc_q <= acc_step;
            end
            // A flush during FIX must leave the architectural outputs untouched.
            if ((state_q == S_FIX) && !kill) begin
                result <= fix_val;
                rd_out <= rd_q;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table for all RV32M ops plus handshake, kill and async-reset sequences.
module tb_muldiv_unit;

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    localparam int LIMIT = 100;

    logic        clk = 1'b0;
    logic        reset, start, kill;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic [4:0]  rd_in;
    logic        ready, busy, done, wb_en;
    logic [4:0]  rd_out;
    logic [31:0] result;

    int n_vec = 0;
    int n_bad = 0;

    muldiv_unit #(.XLEN(32), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .kill(kill), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .ready(ready), .busy(busy),
        .done(done), .wb_en(wb_en), .rd_out(rd_out), .result(result)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        logic        special;
    } vec_t;

    vec_t vt[18];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    // Present an op and return after the accept edge (cycle 1 of the op).
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        funct3 = f3; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!done && lat < LIMIT) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    int lat, exp_lat, ndone, nwb;
    logic [31:0] held;

    initial begin
        reset = 1'b1; start = 1'b0; kill = 1'b0;
        funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;

        vt[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 1'b0};
        vt[1]  = '{3'b001, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000, 1'b0};
        vt[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE, 1'b0};
        vt[3]  = '{3'b010, 32'hFFFFFFFF, 32'd2,        5'd8,  32'hFFFFFFFF, 1'b0};
        vt[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFD, 1'b0};
        vt[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFF, 1'b0};
        vt[6]  = '{3'b101, 32'd100,      32'd7,        5'd11, 32'd14,       1'b0};
        vt[7]  = '{3'b111, 32'd100,      32'd7,        5'd12, 32'd2,        1'b0};
        vt[8]  = '{3'b101, 32'd123,      32'd0,        5'd13, 32'hFFFFFFFF, 1'b1};
        vt[9]  = '{3'b110, 32'd123,      32'd0,        5'd14, 32'd123,      1'b1};
        vt[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 1'b1};
        vt[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'd0,        1'b1};
        vt[12] = '{3'b000, 32'h12345678, 32'h10,       5'd0,  32'h23456780, 1'b0};
        vt[13] = '{3'b110, 32'd7,        32'hFFFFFFFE, 5'd17, 32'd1,        1'b0};
        vt[14] = '{3'b100, 32'd7,        32'hFFFFFFFE, 5'd18, 32'hFFFFFFFD, 1'b0};
        vt[15] = '{3'b001, 32'hFFFFFFFF, 32'd7,        5'd19, 32'hFFFFFFFF, 1'b0};
        vt[16] = '{3'b111, 32'd5,        32'd0,        5'd20, 32'd5,        1'b1};
        vt[17] = '{3'b100, 32'h80000000, 32'd0,        5'd21, 32'hFFFFFFFF, 1'b1};

        #3;
        check("reset ready",  {31'd0, ready},  32'd1);
        check("reset busy",   {31'd0, busy},   32'd0);
        check("reset done",   {31'd0, done},   32'd0);
        check("reset wb_en",  {31'd0, wb_en},  32'd0);
        check("reset rd_out", {27'd0, rd_out}, 32'd0);
        check("reset result", result,          32'd0);
        @(negedge clk); reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            issue(vt[i].f3, vt[i].a, vt[i].b, vt[i].rd);
            wait_done(lat);
            exp_lat = (EARLY && vt[i].special) ? 2 : 34;
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(exp_lat));
            check($sformatf("vec%0d result", i), result, vt[i].exp);
            check($sformatf("vec%0d rd_out", i), {27'd0, rd_out}, {27'd0, vt[i].rd});
            check($sformatf("vec%0d wb_en", i), {31'd0, wb_en}, 32'd1);
            @(posedge clk); #1;
            check($sformatf("vec%0d done pulse", i), {31'd0, done}, 32'd0);
        end

        // Result holds while idle.
        held = result;
        repeat (3) @(posedge clk);
        #1;
        check("idle hold result", result, 32'hFFFFFFFF);

        // Back-to-back: second start presented during the DONE cycle.
        @(negedge clk);
        issue(3'b000, 32'd3, 32'd5, 5'd1);
        wait_done(lat);
        check("b2b op1 result", result, 32'd15);
        issue(3'b101, 32'd100, 32'd7, 5'd2);
        check("b2b op2 accepted", {31'd0, busy}, 32'd1);
        wait_done(lat);
        check("b2b op2 latency", 32'(lat), 32'd34);
        check("b2b op2 result", result, 32'd14);
        check("b2b op2 rd_out", {27'd0, rd_out}, 32'd2);

        // Start while busy must be dropped.
        @(negedge clk);
        issue(3'b000, 32'd6, 32'd7, 5'd3);
        ndone = 0; lat = 0;
        for (int c = 2; c < 70; c++) begin
            if (c == 5) begin
                check("calc busy", {30'd0, busy, ready}, 32'd2);
                funct3 = 3'b000; op_a = 32'd1; op_b = 32'd1; rd_in = 5'd9; start = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                ndone++;
                if (ndone == 1) lat = c;
            end
        end
        check("ignored start done count", 32'(ndone), 32'd1);
        check("ignored start latency", 32'(lat), 32'd34);
        check("ignored start result", result, 32'd42);
        check("ignored start rd_out", {27'd0, rd_out}, 32'd3);

        // Kill at CALC cycle 10.
        @(negedge clk);
        issue(3'b000, 32'd2, 32'd2, 5'd4);
        repeat (9) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill to idle", {30'd0, busy, ready}, 32'd1);
        ndone = 0; nwb = 0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            if (done) ndone++;
            if (wb_en) nwb++;
        end
        check("kill done count", 32'(ndone), 32'd0);
        check("kill wb_en count", 32'(nwb), 32'd0);
        check("kill result kept", result, 32'd42);
        check("kill rd_out kept", {27'd0, rd_out}, 32'd3);

        // Async reset mid-CALC, off the clock edge.
        @(negedge clk);
        issue(3'b000, 32'h55, 32'd3, 5'd11);
        repeat (8) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("async rst ready",  {31'd0, ready},  32'd1);
        check("async rst busy",   {31'd0, busy},   32'd0);
        check("async rst done",   {31'd0, done},   32'd0);
        check("async rst wb_en",  {31'd0, wb_en},  32'd0);
        check("async rst rd_out", {27'd0, rd_out}, 32'd0);
        check("async rst result", result,          32'd0);
        @(negedge clk); reset = 1'b0;

        @(negedge clk);
        issue(3'b000, 32'd3, 32'd4, 5'd7);
        wait_done(lat);
        check("post reset latency", 32'(lat), 32'd34);
        check("post reset result", result, 32'd12);
        check("post reset rd_out", {27'd0, rd_out}, 32'd7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execute unit.
- Takes operands from the register file's rs1/rs2 read ports and returns a 32-bit result plus destination index to the register file's write port.
- Multi-cycle with a start/busy/done handshake; the pipeline stalls on busy.
- One operation in flight at a time.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 5, iteration counter width; must equal log2(XLEN).

Ports:
- clk  input  1  clock
- reset  input  1  async active-high reset
- start  input  1  request new operation; sampled only when ready
- kill  input  1  abort in-flight operation (pipeline flush)
- funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  input  32  rs1 value
- op_b  input  32  rs2 value
- rd_in  input  5  destination register index
- ready  output  1  unit accepts start this cycle
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; result valid
- wb_en  output  1  equals done; drives register file write_enable
- rd_out  output  5  latched rd_in
- result  output  32  operation result

Behaviour:
- States: IDLE, CALC, FIX, DONE.
- Transitions:
  - IDLE --start--> CALC; operands, funct3 and rd latched at the accept edge; counter=0.
  - CALC runs exactly 32 cycles (counter 0..31); at counter==31 --> FIX.
  - FIX runs 1 cycle; applies sign correction, selects lo/hi or quotient/remainder, registers result --> DONE.
  - DONE runs 1 cycle; done=wb_en=1. Goes --start--> CALC (back-to-back), else --> IDLE.
- Latency: done is high exactly 34 cycles after the accept edge.
- ready=1 in IDLE and DONE. busy=1 in CALC and FIX. start while busy is ignored and never queued.
- Multiply:
  - Convert operands to magnitudes per signedness: MULH both signed; MULHSU a signed, b unsigned; MULHU/MUL unsigned-equivalent.
  - Shift-add one bit per CALC cycle into a 64-bit product.
  - FIX negates the product if the signs differ; MUL returns bits [31:0], MULH* return [63:32].
- Divide:
  - Restoring, one quotient bit per CALC cycle on magnitudes.
  - FIX: quotient negated if dividend sign differs from divisor sign; remainder takes dividend sign.
- Special cases (FIX overrides the iterative result):
  - Divide by zero: DIV/DIVU quotient=0xFFFFFFFF; REM/REMU remainder=op_a.
  - Signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF): DIV=0x80000000, REM=0.
- result and rd_out hold their value after done until the next FIX; result is not cleared on IDLE.
- wb_en is asserted even when rd_out==0; the register file discards writes to x0.
- kill: in any state forces IDLE at the next edge. No done is produced and result is unchanged. kill and start in the same cycle: kill wins.
- reset (async, any state): state=IDLE, counter=0, ready=1, busy=0, done=0, wb_en=0, rd_out=0, result=0.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- Defined: divide by zero and signed overflow are detected at accept and go IDLE/DONE --> FIX directly, skipping CALC; done is high 2 cycles after the accept edge. Multiply latency is unchanged.
- Undefined: all operations take 34 cycles; special cases are resolved only in FIX.

Decomposition:
- Shared package riscv_m_pkg: funct3 localparams (F3_MUL..F3_REMU), state encoding constants, XLEN.
- No sub-module needed; sign conditioning is a package function (abs with sign flag).
- Single module muldiv_unit.

Test Plan:
- MUL op_a=7, op_b=0xFFFFFFFD, rd_in=5 -> after 34 cycles: done=1 for one cycle, result=0xFFFFFFEB, rd_out=5, wb_en=1.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 123/0 -> 0xFFFFFFFF; REM 123/0 -> 123; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0. With MULDIV_EARLY_OUT_EN, each gives done 2 cycles after accept.
- Handshake:
  - start pulsed in the DONE cycle -> next op accepted back-to-back.
  - start during CALC -> ignored; exactly one done.
  - kill at CALC cycle 10 -> IDLE, no done/wb_en, result unchanged.
- Async reset asserted mid-CALC (off clock edge) -> outputs immediately at reset values.
- After release, MUL 3x4 -> 12 with normal 34-cycle latency.
